// File: rtl/control_unit.sv
// Multi-cycle instruction sequencer: fetches 16-bit words from a synchronous ROM and
// drives register-file / data-memory / ALU controls, one Moore state per machine step.
module control_unit #(
    parameter int PC_W = 7
) (
    input  logic            Clk,
    input  logic            ResetN,
    input  logic [15:0]     InstrData,
    output logic [PC_W-1:0] PCAddr,
    output logic [7:0]      DAddr,
    output logic            DWrite,
    output logic            RFSelect,
    output logic [3:0]      WriteAddr,
    output logic            RFWriteEnable,
    output logic [3:0]      ReadAddrA,
    output logic [3:0]      ReadAddrB,
    output logic [2:0]      ALUSelect,
    output logic [15:0]     IROut,
    output logic [3:0]      StateOut,
    output logic            Halted
);

    typedef enum logic [3:0] {
        S_INIT   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_LOADA  = 4'd3,
        S_LOADB  = 4'd4,
        S_STORE  = 4'd5,
        S_ADD    = 4'd6,
        S_SUB    = 4'd7,
        S_HALT   = 4'd8,
        S_NOOP   = 4'd9
    } state_t;

    typedef struct packed {
        logic [7:0] daddr;
        logic       dwrite;
        logic       rf_sel;
        logic [3:0] waddr;
        logic       rf_we;
        logic [3:0] ra;
        logic [3:0] rb;
        logic [2:0] alu;
        logic       halted;
    } ctl_t;

    state_t          state;
    logic [PC_W-1:0] pc;
    logic [15:0]     ir;
    ctl_t            ctl;
    state_t          dec_state;

    function automatic state_t op_state(input logic [3:0] op);
        case (op)
            4'b0010: return S_LOADA;
            4'b0001: return S_STORE;
            4'b0011: return S_ADD;
            4'b0100: return S_SUB;
            4'b0101: return S_HALT;
            default: return S_NOOP;
        endcase
    endfunction

    // Control word for the state being entered; f is the IR operand field.
    function automatic ctl_t ctl_for(input state_t s, input logic [11:0] f);
        ctl_t c;
        c = '0;
        case (s)
            S_LOADA, S_LOADB: begin
                c.daddr  = f[11:4];
                c.rf_sel = 1'b1;
                c.waddr  = f[3:0];
                c.rf_we  = (s == S_LOADB);
            end
            S_STORE: begin
                c.daddr  = f[11:4];
                c.ra     = f[3:0];
                c.dwrite = 1'b1;
            end
            S_ADD, S_SUB: begin
                c.ra    = f[11:8];
                c.rb    = f[7:4];
                c.waddr = f[3:0];
                c.rf_we = 1'b1;
                c.alu   = (s == S_ADD) ? 3'b001 : 3'b010;
            end
            S_HALT:  c.halted = 1'b1;
            default: ;
        endcase
        return c;
    endfunction

    assign dec_state = op_state(InstrData[15:12]);

    // Outputs are registered alongside the state they belong to, so InstrData
    // only ever reaches an output through a flop.
    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            state <= S_INIT;
            pc    <= '0;
            ir    <= '0;
            ctl   <= '0;
        end else begin
            case (state)
                S_INIT: begin
                    state <= S_FETCH;
                    pc    <= '0;
                    ir    <= '0;
                    ctl   <= ctl_for(S_FETCH, 12'h000);
                end
                S_FETCH: begin
                    state <= S_DECODE;
                    ctl   <= ctl_for(S_DECODE, ir[11:0]);
                end
                S_DECODE: begin
                    ir    <= InstrData;
                    pc    <= pc + PC_W'(1);
                    state <= dec_state;
                    ctl   <= ctl_for(dec_state, InstrData[11:0]);
                end
                S_LOADA: begin
                    state <= S_LOADB;
                    ctl   <= ctl_for(S_LOADB, ir[11:0]);
                end
                S_HALT: begin
                    state <= S_HALT;
                    ctl   <= ctl_for(S_HALT, ir[11:0]);
                end
                default: begin
                    state <= S_FETCH;
                    ctl   <= ctl_for(S_FETCH, ir[11:0]);
                end
            endcase
        end
    end

    assign PCAddr        = pc;
    assign IROut         = ir;
    assign StateOut      = state;
    assign DAddr         = ctl.daddr;
    assign DWrite        = ctl.dwrite;
    assign RFSelect      = ctl.rf_sel;
    assign WriteAddr     = ctl.waddr;
    assign RFWriteEnable = ctl.rf_we;
    assign ReadAddrA     = ctl.ra;
    assign ReadAddrB     = ctl.rb;
    assign ALUSelect     = ctl.alu;
    assign Halted        = ctl.halted;

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: a per-instruction reference model expands ROM contents into
// an expected cycle trace that is compared cycle by cycle against the DUT.
module tb_control_unit;
    localparam int PC_W  = 7;
    localparam int DEPTH = 128;

    logic            Clk = 1'b0;
    logic            ResetN = 1'b1;
    logic [15:0]     InstrData;
    logic [PC_W-1:0] PCAddr;
    logic [7:0]      DAddr;
    logic            DWrite, RFSelect, RFWriteEnable, Halted;
    logic [3:0]      WriteAddr, ReadAddrA, ReadAddrB, StateOut;
    logic [2:0]      ALUSelect;
    logic [15:0]     IROut;

    control_unit #(.PC_W(PC_W)) dut (
        .Clk(Clk), .ResetN(ResetN), .InstrData(InstrData), .PCAddr(PCAddr),
        .DAddr(DAddr), .DWrite(DWrite), .RFSelect(RFSelect), .WriteAddr(WriteAddr),
        .RFWriteEnable(RFWriteEnable), .ReadAddrA(ReadAddrA), .ReadAddrB(ReadAddrB),
        .ALUSelect(ALUSelect), .IROut(IROut), .StateOut(StateOut), .Halted(Halted)
    );

    always #5 Clk = ~Clk;

    logic [15:0] rom [DEPTH];
    always @(posedge Clk) InstrData <= rom[PCAddr];

    int          checks = 0;
    int          errors = 0;
    int          pc_m;
    logic [15:0] ir_m;
    bit          halt_m;
    logic [63:0] exp_q[$];

    function automatic logic [63:0] mk(input logic [3:0] st, input logic [6:0] p,
            input logic [15:0] ir, input logic [7:0] da, input logic dw, input logic rs,
            input logic [3:0] wa, input logic we, input logic [3:0] ra, input logic [3:0] rb,
            input logic [2:0] alu, input logic h);
        return {10'b0, st, p, ir, da, dw, rs, wa, we, ra, rb, alu, h};
    endfunction

    function automatic logic [63:0] obs();
        return {10'b0, StateOut, PCAddr, IROut, DAddr, DWrite, RFSelect, WriteAddr,
                RFWriteEnable, ReadAddrA, ReadAddrB, ALUSelect, Halted};
    endfunction

    task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    // Expand the next instruction (or one Halt cycle) into expected cycles.
    task automatic model_instr();
        logic [15:0] w;
        logic [6:0]  p;
        p = pc_m[6:0];
        if (halt_m) begin
            exp_q.push_back(mk(4'd8, p, ir_m, 8'h0, 1'b0, 1'b0, 4'h0, 1'b0, 4'h0, 4'h0, 3'd0, 1'b1));
            return;
        end
        w = rom[p];
        exp_q.push_back(mk(4'd1, p, ir_m, 8'h0, 1'b0, 1'b0, 4'h0, 1'b0, 4'h0, 4'h0, 3'd0, 1'b0));
        exp_q.push_back(mk(4'd2, p, ir_m, 8'h0, 1'b0, 1'b0, 4'h0, 1'b0, 4'h0, 4'h0, 3'd0, 1'b0));
        ir_m = w;
        pc_m = (pc_m + 1) % DEPTH;
        p = pc_m[6:0];
        case (w[15:12])
            4'h2: begin
                exp_q.push_back(mk(4'd3, p, w, w[11:4], 1'b0, 1'b1, w[3:0], 1'b0, 4'h0, 4'h0, 3'd0, 1'b0));
                exp_q.push_back(mk(4'd4, p, w, w[11:4], 1'b0, 1'b1, w[3:0], 1'b1, 4'h0, 4'h0, 3'd0, 1'b0));
            end
            4'h1: exp_q.push_back(mk(4'd5, p, w, w[11:4], 1'b1, 1'b0, 4'h0, 1'b0, w[3:0], 4'h0, 3'd0, 1'b0));
            4'h3: exp_q.push_back(mk(4'd6, p, w, 8'h0, 1'b0, 1'b0, w[3:0], 1'b1, w[11:8], w[7:4], 3'd1, 1'b0));
            4'h4: exp_q.push_back(mk(4'd7, p, w, 8'h0, 1'b0, 1'b0, w[3:0], 1'b1, w[11:8], w[7:4], 3'd2, 1'b0));
            4'h5: begin
                halt_m = 1'b1;
                exp_q.push_back(mk(4'd8, p, w, 8'h0, 1'b0, 1'b0, 4'h0, 1'b0, 4'h0, 4'h0, 3'd0, 1'b1));
            end
            default: exp_q.push_back(mk(4'd9, p, w, 8'h0, 1'b0, 1'b0, 4'h0, 1'b0, 4'h0, 4'h0, 3'd0, 1'b0));
        endcase
    endtask

    task automatic run_expect(input string tag, input int n);
        for (int c = 0; c < n; c++) begin
            if (exp_q.size() == 0) model_instr();
            @(posedge Clk);
            #1;
            chk(tag, obs(), exp_q.pop_front());
            chk("we_excl", {63'b0, DWrite & RFWriteEnable}, 64'b0);
        end
    endtask

    // Asserts reset away from any clock edge and checks outputs clear before the next edge.
    task automatic do_reset(input string tag);
        ResetN = 1'b0;
        #2;
        chk(tag, obs(), 64'b0);
        pc_m   = 0;
        ir_m   = 16'h0;
        halt_m = 1'b0;
        exp_q.delete();
        @(negedge Clk);
        ResetN = 1'b1;
    endtask

    task automatic fill_rom(input logic [15:0] v);
        for (int i = 0; i < DEPTH; i++) rom[i] = v;
    endtask

    initial begin
        logic [3:0] op;
        fill_rom(16'h0000);
        #1;
        do_reset("reset_initial");

        // Directed program: LOAD, ADD, SUB, STORE, HALT, then sit in Halt.
        fill_rom(16'h0000);
        rom[0] = 16'h2001; rom[1] = 16'h3012; rom[2] = 16'h4013;
        rom[3] = 16'h1092; rom[4] = 16'h5000;
        do_reset("reset_prog");
        run_expect("prog", 16 + 25);

        // Undefined opcode takes the Noop path.
        fill_rom(16'h5000);
        rom[0] = 16'hF123;
        do_reset("reset_noop");
        run_expect("undef_op", 3 + 3 + 20);

        // Reset pulsed during Store, then restart from ROM[0].
        fill_rom(16'h0000);
        rom[0] = 16'h1092; rom[1] = 16'h3456;
        do_reset("reset_store_pre");
        run_expect("store", 3);
        do_reset("reset_mid_store");
        run_expect("store_restart", 9);

        // Reset pulsed during LoadB.
        rom[0] = 16'h2A57;
        do_reset("reset_loadb_pre");
        run_expect("loadb", 4);
        do_reset("reset_mid_loadb");
        run_expect("loadb_restart", 7);

        // 128+ non-halting instructions without loads: PC must wrap 127 -> 0.
        for (int i = 0; i < DEPTH; i++) begin
            op = 4'($urandom_range(6, 16));
            if (op == 4'h0 || i == 127) op = 4'h0;
            rom[i] = {op, 12'($urandom)};
        end
        rom[0] = 16'hF123;
        do_reset("reset_wrap");
        run_expect("pc_wrap", DEPTH * 3 + 6);

        // Random programs over every opcode; HALT is made rare.
        for (int s = 0; s < 4; s++) begin
            for (int i = 0; i < DEPTH; i++) begin
                op = 4'($urandom_range(0, 15));
                if (op == 4'h5 && $urandom_range(0, 15) != 0) op = 4'h3;
                rom[i] = {op, 12'($urandom)};
            end
            do_reset("reset_rand");
            run_expect("rand", 200);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
